// File: rtl/mem_access_unit.sv
// MEM stage: byte-addressable data memory with sized/extended loads and stores,
// misalignment detection, branch resolution and the MEM/WB pipeline register.
module mem_access_unit #(
    parameter int ADDR_BITS = 10,
    parameter int REG_BITS  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic                stall,
    input  logic                flush,
    input  logic                branch,
    input  logic                zero,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [1:0]          mem_size,
    input  logic                mem_unsigned,
    input  logic [31:0]         address,
    input  logic [31:0]         write_data,
    input  logic                reg_write_in,
    input  logic                mem_to_reg_in,
    input  logic [REG_BITS-1:0] write_reg_in,
    output logic                pc_src,
    output logic                valid_out,
    output logic [31:0]         load_data,
    output logic [31:0]         alu_result_out,
    output logic                reg_write_out,
    output logic                mem_to_reg_out,
    output logic [REG_BITS-1:0] write_reg_out,
    output logic                misaligned_out
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0]          mem_q [DEPTH];
    logic [ADDR_BITS-1:0] widx;
    logic                 live, misaligned, mem_we;
    logic [3:0]           byte_en;
    logic [31:0]          wr_lanes;

    logic                valid_q, valid_d;
    logic                reg_write_q, reg_write_d;
    logic                mem_to_reg_q, mem_to_reg_d;
    logic [REG_BITS-1:0] write_reg_q, write_reg_d;
    logic                mis_q, mis_d;
    logic [31:0]         alu_q, alu_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                ld_mis_q, ld_mis_d;
    logic [31:0]         rdata_q;

    assign live       = valid_in & ~flush & ~stall;
    assign pc_src     = branch & zero & valid_in & ~flush;
    assign widx       = address[ADDR_BITS+1:2];
    assign misaligned = ((mem_size == 2'b01) & address[0]) |
                        (mem_size[1] & (address[1:0] != 2'b00));
    assign mem_we     = live & mem_write & ~misaligned & ~rst;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en  = 4'b1111;
        wr_lanes = write_data;
        case (mem_size)
            2'b00: begin
                byte_en  = 4'b0001 << address[1:0];
                wr_lanes = {4{write_data[7:0]}};
            end
            2'b01: begin
                byte_en  = address[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{write_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem_q[widx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        write_reg_d  = write_reg_q;
        mis_d        = mis_q;
        alu_d        = alu_q;
        size_d       = size_q;
        uns_d        = uns_q;
        ld_mis_d     = ld_mis_q;
        if (!stall) begin
            valid_d      = valid_in & ~flush;
            reg_write_d  = ~flush & reg_write_in & ~(misaligned & mem_read);
            mem_to_reg_d = mem_to_reg_in;
            write_reg_d  = write_reg_in;
            mis_d        = misaligned & (mem_read | mem_write) & live;
            alu_d        = address;
            size_d       = mem_size;
            uns_d        = mem_unsigned;
            ld_mis_d     = misaligned & mem_read;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            write_reg_q  <= '0;
            mis_q        <= 1'b0;
            alu_q        <= '0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            ld_mis_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            write_reg_q  <= write_reg_d;
            mis_q        <= mis_d;
            alu_q        <= alu_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            ld_mis_q     <= ld_mis_d;
            if (!stall) rdata_q <= mem_q[widx];
        end
    end

    // Lane select and extension use the registered address/size of the load.
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    always_comb begin
        case (alu_q[1:0])
            2'b00:   rd_byte = rdata_q[7:0];
            2'b01:   rd_byte = rdata_q[15:8];
            2'b10:   rd_byte = rdata_q[23:16];
            default: rd_byte = rdata_q[31:24];
        endcase
        rd_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q)
            2'b00:   load_data = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_data = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_data = rdata_q;
        endcase
        if (ld_mis_q) load_data = '0;
    end

    assign valid_out      = valid_q;
    assign reg_write_out  = reg_write_q;
    assign mem_to_reg_out = mem_to_reg_q;
    assign write_reg_out  = write_reg_q;
    assign misaligned_out = mis_q;
    assign alu_result_out = alu_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: reset, sized loads/stores, misalignment,
// stall/flush, branch resolution and address aliasing.
module tb_mem_access_unit;
    localparam int ADDR_BITS = 10;
    localparam int REG_BITS  = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                valid_in, stall, flush, branch, zero;
    logic                mem_read, mem_write, mem_unsigned;
    logic [1:0]          mem_size;
    logic [31:0]         address, write_data;
    logic                reg_write_in, mem_to_reg_in;
    logic [REG_BITS-1:0] write_reg_in;
    logic                pc_src, valid_out, reg_write_out, mem_to_reg_out, misaligned_out;
    logic [31:0]         load_data, alu_result_out;
    logic [REG_BITS-1:0] write_reg_out;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.ADDR_BITS(ADDR_BITS), .REG_BITS(REG_BITS)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .flush(flush),
        .branch(branch), .zero(zero), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .address(address),
        .write_data(write_data), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .write_reg_in(write_reg_in), .pc_src(pc_src), .valid_out(valid_out),
        .load_data(load_data), .alu_result_out(alu_result_out), .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out), .write_reg_out(write_reg_out),
        .misaligned_out(misaligned_out)
    );

    always #5 clk = ~clk;

    task automatic idle();
        valid_in = 0; stall = 0; flush = 0; branch = 0; zero = 0;
        mem_read = 0; mem_write = 0; mem_size = 2'b10; mem_unsigned = 0;
        address = 0; write_data = 0; reg_write_in = 0; mem_to_reg_in = 0; write_reg_in = 0;
    endtask

    task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [REG_BITS-1:0] rdst);
        idle();
        valid_in = 1; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
        address = addr; write_data = wd; reg_write_in = rd; mem_to_reg_in = rd; write_reg_in = rdst;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        op(0, 1, 2'b10, 0, 32'h40, 32'h0BADF00D, 0); step();
        op(1, 0, 2'b10, 0, 32'h40, 0, 5'd3); step();
        n_checks++;
        if (valid_out !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b expected 1", valid_out); end
        op(0, 1, 2'b10, 0, 32'h40, 32'h12345678, 5'd4);
        #2 rst = 1;
        #1;
        n_checks++;
        if ({valid_out, reg_write_out, mem_to_reg_out, misaligned_out} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000",
                               {valid_out, reg_write_out, mem_to_reg_out, misaligned_out});
        end
        n_checks++;
        if (load_data !== 32'h0 || alu_result_out !== 32'h0 || write_reg_out !== '0) begin
            n_fail++; $display("FAIL reset_data: load %h alu %h reg %0d expected all 0",
                               load_data, alu_result_out, write_reg_out);
        end
        step(); step();
        rst = 0;
        op(1, 0, 2'b10, 0, 32'h40, 0, 5'd3); step();
        check32("reset_no_store", load_data, 32'h0BADF00D);
    endtask

    task automatic test_word();
        op(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0); step();
        n_checks++;
        if (misaligned_out !== 1'b0 || valid_out !== 1'b1) begin
            n_fail++; $display("FAIL sw_flags: mis %b valid %b expected 0 1", misaligned_out, valid_out);
        end
        op(1, 0, 2'b10, 0, 32'h10, 0, 5'd9); step();
        check32("lw_data", load_data, 32'hDEADBEEF);
        check32("lw_alu", alu_result_out, 32'h10);
        n_checks++;
        if ({valid_out, reg_write_out, mem_to_reg_out} !== 3'b111 || write_reg_out !== 5'd9) begin
            n_fail++; $display("FAIL lw_ctrl: got %b reg %0d expected 111 reg 9",
                               {valid_out, reg_write_out, mem_to_reg_out}, write_reg_out);
        end
    endtask

    task automatic test_extension();
        op(0, 1, 2'b10, 0, 32'h20, 32'h80FF7F01, 0); step();
        op(1, 0, 2'b00, 0, 32'h23, 0, 1); step(); check32("lb_23", load_data, 32'hFFFFFF80);
        op(1, 0, 2'b00, 1, 32'h23, 0, 1); step(); check32("lbu_23", load_data, 32'h00000080);
        op(1, 0, 2'b01, 0, 32'h22, 0, 1); step(); check32("lh_22", load_data, 32'hFFFF80FF);
        op(1, 0, 2'b01, 1, 32'h20, 0, 1); step(); check32("lhu_20", load_data, 32'h00007F01);
        op(1, 0, 2'b00, 0, 32'h21, 0, 1); step(); check32("lb_21", load_data, 32'h0000007F);
        op(0, 1, 2'b00, 0, 32'h21, 32'h123456AA, 0); step();
        op(1, 0, 2'b10, 0, 32'h20, 0, 1); step(); check32("sb_then_lw", load_data, 32'h80FFAA01);
        op(0, 1, 2'b01, 0, 32'h32, 32'hFFFF1234, 0); step();
        op(0, 1, 2'b10, 0, 32'h30, 32'h0, 0); step();
        op(0, 1, 2'b01, 0, 32'h32, 32'hFFFF1234, 0); step();
        op(1, 0, 2'b10, 0, 32'h30, 0, 1); step(); check32("sh_then_lw", load_data, 32'h12340000);
    endtask

    task automatic test_misalign();
        op(0, 1, 2'b10, 0, 32'h12, 32'h11111111, 0); step();
        n_checks++;
        if (misaligned_out !== 1'b1) begin n_fail++; $display("FAIL sw_mis_flag: got %b expected 1", misaligned_out); end
        op(1, 0, 2'b10, 0, 32'h10, 0, 2); step(); check32("sw_mis_no_write", load_data, 32'hDEADBEEF);
        op(1, 0, 2'b01, 0, 32'h21, 0, 2); step();
        check32("lh_mis_data", load_data, 32'h0);
        n_checks++;
        if (reg_write_out !== 1'b0 || misaligned_out !== 1'b1) begin
            n_fail++; $display("FAIL lh_mis_ctrl: rw %b mis %b expected 0 1", reg_write_out, misaligned_out);
        end
        op(1, 0, 2'b11, 0, 32'h22, 0, 2); step();
        n_checks++;
        if (misaligned_out !== 1'b1 || load_data !== 32'h0) begin
            n_fail++; $display("FAIL rsv_mis: mis %b data %h expected 1 0", misaligned_out, load_data);
        end
        op(0, 0, 2'b10, 0, 32'h13, 0, 6); reg_write_in = 1; step();
        n_checks++;
        if (reg_write_out !== 1'b1 || misaligned_out !== 1'b0) begin
            n_fail++; $display("FAIL alu_not_gated: rw %b mis %b expected 1 0", reg_write_out, misaligned_out);
        end
    endtask

    task automatic test_stall_flush();
        op(1, 0, 2'b10, 0, 32'h20, 0, 5'd7); step();
        check32("pre_stall", load_data, 32'h80FFAA01);
        op(1, 0, 2'b10, 0, 32'h10, 0, 5'd9); stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (load_data !== 32'h80FFAA01 || alu_result_out !== 32'h20 ||
                write_reg_out !== 5'd7 || valid_out !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold[%0d]: data %h alu %h reg %0d valid %b expected 80ffaa01 20 7 1",
                                   i, load_data, alu_result_out, write_reg_out, valid_out);
            end
        end
        stall = 0; step();
        check32("after_stall", load_data, 32'hDEADBEEF);
        op(0, 1, 2'b10, 0, 32'h10, 32'h55555555, 0); stall = 1; step();
        op(1, 0, 2'b10, 0, 32'h10, 0, 1); step();
        check32("stall_no_store", load_data, 32'hDEADBEEF);
        op(1, 0, 2'b10, 0, 32'h10, 0, 1); flush = 1; step();
        n_checks++;
        if (valid_out !== 1'b0 || reg_write_out !== 1'b0) begin
            n_fail++; $display("FAIL flush_ctrl: valid %b rw %b expected 0 0", valid_out, reg_write_out);
        end
        op(0, 1, 2'b10, 0, 32'h12, 32'h77777777, 0); flush = 1; step();
        n_checks++;
        if (misaligned_out !== 1'b0) begin n_fail++; $display("FAIL flush_mis: got %b expected 0", misaligned_out); end
        op(0, 1, 2'b10, 0, 32'h10, 32'h77777777, 0); flush = 1; step();
        op(1, 0, 2'b10, 0, 32'h10, 0, 1); step();
        check32("flush_no_store", load_data, 32'hDEADBEEF);
    endtask

    task automatic test_branch();
        idle(); valid_in = 1; branch = 1; zero = 1; #1;
        n_checks++;
        if (pc_src !== 1'b1) begin n_fail++; $display("FAIL br_taken: got %b expected 1", pc_src); end
        flush = 1; #1;
        n_checks++;
        if (pc_src !== 1'b0) begin n_fail++; $display("FAIL br_flush: got %b expected 0", pc_src); end
        flush = 0; zero = 0; #1;
        n_checks++;
        if (pc_src !== 1'b0) begin n_fail++; $display("FAIL br_nozero: got %b expected 0", pc_src); end
        zero = 1; valid_in = 0; #1;
        n_checks++;
        if (pc_src !== 1'b0) begin n_fail++; $display("FAIL br_invalid: got %b expected 0", pc_src); end
        idle(); step();
    endtask

    task automatic test_alias();
        op(0, 1, 2'b10, 0, 32'h0, 32'hCAFEF00D, 0); step();
        op(1, 0, 2'b10, 0, 32'h4 << ADDR_BITS, 0, 1); step();
        check32("alias_load", load_data, 32'hCAFEF00D);
        check32("alias_alu", alu_result_out, 32'h1000);
    endtask

    initial begin
        idle();
        rst = 1;
        step(); step();
        rst = 0;
        test_reset();
        test_word();
        test_extension();
        test_misalign();
        test_stall_flush();
        test_branch();
        test_alias();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
